restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  dividend, unsigned; captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  divisor, unsigned; captured on the accepting edge.
REQ-007 SHALL have port quotient  output  WIDTH  result quotient, registered.
REQ-008 SHALL have port remainder  output  WIDTH  result remainder, registered.
REQ-009 SHALL have port busy  output  1  high from the accepting edge until done is asserted.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port div_by_zero  output  1  high with done when captured b was 0; held until the next accept.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FINISH; FINISH lasts exactly one cycle and returns to IDLE.
REQ-013 SHALL accept on a rising edge in IDLE with start=1: capture a and b, clear the partial remainder, clear the iteration counter, set busy=1.
REQ-014 SHALL, when the captured b is 0, go IDLE->FINISH directly: quotient = all ones, remainder = captured a, div_by_zero=1.
REQ-015 SHALL, when the captured b is nonzero, go IDLE->RUN and perform one restoring step per edge, MSB of dividend first.
REQ-016 SHALL define each step as: shift {remainder, dividend} left by 1; trial = remainder - b; if no borrow, keep trial and set quotient bit to 1, else restore and set it to 0.
REQ-017 SHALL compute the trial subtraction at WIDTH+1 bits so that the borrow-out is the restore decision.
REQ-018 SHALL perform exactly WIDTH steps; the WIDTH-th step edge enters FINISH and registers quotient and remainder.
REQ-019 SHALL assert done=1 and busy=0 throughout FINISH; latency from the accepting edge to done high is WIDTH edges (1 edge for divide by zero).
REQ-020 SHALL ignore start while busy=1 or in FINISH; a request is accepted only on an IDLE edge.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable from FINISH until the next accept.
REQ-022 SHALL let an accept on the edge that leaves FINISH take effect on the next IDLE edge only (no back-to-back accept inside FINISH).
REQ-023 SHALL satisfy quotient*b + remainder == a with remainder < b for every b != 0, including a < b (quotient 0) and a == 0.

Reset
REQ-024 SHALL, with rst_n=0, immediately force: state IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-025 SHALL, when reset occurs mid-operation, abandon the division with no done pulse; after release the next accept starts cleanly.
REQ-026 SHALL wait for the first rising edge after rst_n rises before it can accept a request.

Structure
REQ-027 SHALL keep the FSM state encoding (IDLE, RUN, FINISH) and the default WIDTH in a shared package, divider_pkg.
REQ-028 SHALL contain one sub-module, ripple_subtractor (WIDTH+1 bits, borrow-out), that provides the trial subtraction as a chain of full-subtractor cells.
REQ-029 SHALL contain no latches, no combinational path from the inputs to the outputs, and a counter sized clog2(WIDTH)+1.

Verification (WIDTH=4)
REQ-030 SHALL check: a=13, b=4, start pulse -> done 4 edges later; quotient=3, remainder=1, div_by_zero=0.
REQ-031 SHALL check: a=15, b=1 -> quotient=15, remainder=0; then a=7, b=8 -> quotient=0, remainder=7.
REQ-032 SHALL check: a=9, b=0 -> done 1 edge after accept; quotient=15, remainder=9, div_by_zero=1.
REQ-033 SHALL check: a=12, b=5 accepted, then start held high with a=3, b=1 during RUN -> result stays quotient=2, remainder=2; second request accepted only after IDLE is re-entered.
REQ-034 SHALL check: rst_n low after 2 steps of a=14, b=3 -> all outputs 0, no done pulse; after release, a=14, b=3 -> quotient=4, remainder=2.
REQ-035 SHALL check: exhaustive sweep of all 256 (a, b) pairs against a reference model, including done-pulse width = 1.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and defaults for the restoring divider.
// Holds the FSM state encoding and the default operand width.
package divider_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_subtractor.sv
// N-bit ripple-borrow subtractor built from full-subtractor cells.
// diff = x - y; bout is the borrow out of the top cell.
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]  = x[i] ^ y[i] ^ bw[i];
    assign bw[i+1]  = (~x[i] & y[i]) |
                      (~(x[i] ^ y[i]) & bw[i]);
  end

  assign bout = bw[N];

endmodule

// File: rtl/restoring_divider.sv
// Unsigned multi-cycle restoring divider, one quotient bit per clock.
// Accept edge captures operands; following edges do the steps.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             unused_msb;
  logic [WIDTH-1:0] nrem;
  logic [WIDTH-1:0] ndvd;

  assign shifted = {rem, dvd[WIDTH-1]};

  ripple_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .x   (shifted),
    .y   ({1'b0, dvs}),
    .diff(diff),
    .bout(borrow)
  );

  // A successful trial always fits, so the top diff bit is zero.
  assign unused_msb = diff[WIDTH];
  assign nrem = borrow ? shifted[WIDTH-1:0]
                       : diff[WIDTH-1:0];
  assign ndvd = {dvd[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!busy) begin
            if (start) begin
              dvd         <= a;
              dvs         <= b;
              rem         <= '0;
              cnt         <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else if (dvs == '0) begin
            state       <= FINISH;
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            rem   <= nrem;
            dvd   <= ndvd;
            cnt   <= cnt + 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          rem <= nrem;
          dvd <= ndvd;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= FINISH;
            quotient  <= ndvd;
            remainder <= nrem;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider at WIDTH=4.
// Directed table, multi-cycle sequences, exhaustive and random sweeps.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int nvec;
  int nerr;

  restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic, with the divide-by-zero convention.
  task automatic model(input int ia, input int ib,
                       output int q, output int r,
                       output int z, output int lat);
    if (ib == 0) begin
      q = (1 << W) - 1; r = ia; z = 1; lat = 1;
    end else begin
      q = ia / ib; r = ia % ib; z = 0; lat = W;
    end
  endtask

  // Issue one request, measure latency to done and the done width.
  task automatic run_div(input int ia, input int ib,
                         output int lat, output int q,
                         output int r, output int z,
                         output int width, output int bsy);
    @(negedge clk);
    a = W'(ia); b = W'(ib); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bsy = int'(busy);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
    width = 0;
    while (done && width < 5) begin
      width++;
      @(posedge clk); #1;
    end
  endtask

  task automatic full_check(input string tag, input int ia,
                            input int ib);
    int lat, q, r, z, w, bsy;
    int eq, er, ez, el;
    model(ia, ib, eq, er, ez, el);
    run_div(ia, ib, lat, q, r, z, w, bsy);
    chk({tag, " quotient"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " div_by_zero"}, z, ez);
    chk({tag, " latency"}, lat, el);
    chk({tag, " done_width"}, w, 1);
    chk({tag, " busy_after_accept"}, bsy, 1);
    chk({tag, " hold_quotient"}, int'(quotient), eq);
    chk({tag, " hold_remainder"}, int'(remainder), er);
  endtask

  initial begin
    vec_t tbl[6];
    int lat, q, r, z, w, bsy, cyc, seen;

    nvec = 0; nerr = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

    tbl[0] = '{a: 13, b: 4, q: 3,  r: 1, z: 0, lat: 4};
    tbl[1] = '{a: 15, b: 1, q: 15, r: 0, z: 0, lat: 4};
    tbl[2] = '{a: 7,  b: 8, q: 0,  r: 7, z: 0, lat: 4};
    tbl[3] = '{a: 9,  b: 0, q: 15, r: 9, z: 1, lat: 1};
    tbl[4] = '{a: 0,  b: 5, q: 0,  r: 0, z: 0, lat: 4};
    tbl[5] = '{a: 15, b: 15, q: 1, r: 0, z: 0, lat: 4};

    #1;
    chk("reset_outputs",
        int'({quotient, remainder, busy, done, div_by_zero}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_div(tbl[i].a, tbl[i].b, lat, q, r, z, w, bsy);
      chk($sformatf("tbl%0d quotient", i), q, tbl[i].q);
      chk($sformatf("tbl%0d remainder", i), r, tbl[i].r);
      chk($sformatf("tbl%0d div_by_zero", i), z, tbl[i].z);
      chk($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d done_width", i), w, 1);
    end

    // start held high through a run: second request waits for IDLE
    @(negedge clk);
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a = 4'd3; b = 4'd1;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_start latency", lat, 4);
    chk("hold_start quotient", int'(quotient), 2);
    chk("hold_start remainder", int'(remainder), 2);
    @(posedge clk); #1;
    chk("hold_start no_accept_in_finish", int'(busy), 0);
    @(posedge clk); #1;
    chk("hold_start accept_in_idle", int'(busy), 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("second latency", lat, 4);
    chk("second quotient", int'(quotient), 3);
    chk("second remainder", int'(remainder), 0);
    @(posedge clk); #1;

    // reset mid-operation after two steps
    @(negedge clk);
    a = 4'd14; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        int'({quotient, remainder, busy, done, div_by_zero}), 0);
    seen = 0;
    for (cyc = 0; cyc < 2; cyc++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("midreset no_done", seen, 0);
    chk("midreset idle_after", int'(busy), 0);
    run_div(14, 3, lat, q, r, z, w, bsy);
    chk("after_reset quotient", q, 4);
    chk("after_reset remainder", r, 2);
    chk("after_reset latency", lat, 4);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        full_check($sformatf("sweep a=%0d b=%0d", ia, ib), ia, ib);

    for (int k = 0; k < 64; k++) begin
      int ra, rb;
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      repeat ($urandom_range(2, 0)) @(posedge clk);
      full_check($sformatf("rand a=%0d b=%0d", ra, rb), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
